// File: rtl/reg_mem_pkg.sv
// Shared types and helpers for the dual-read register-file memory.
package reg_mem_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } rm_state_t;

  function automatic int unsigned depth_of(input int unsigned abits);
    return 32'd1 << abits;
  endfunction

endpackage

// File: rtl/reg_mem_dp_if.sv
// Request/response bundle for reg_mem_dp: one write port, two read ports, clear.
interface reg_mem_dp_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_BITS  = 3
);
  logic                  wen;
  logic [ADDR_BITS-1:0]  waddr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ren_a;
  logic [ADDR_BITS-1:0]  raddr_a;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic                  rvalid_a;
  logic                  ren_b;
  logic [ADDR_BITS-1:0]  raddr_b;
  logic [DATA_WIDTH-1:0] rdata_b;
  logic                  rvalid_b;
  logic                  clr;
  logic                  busy;
  logic                  err;

  modport master (
    output wen, waddr, data_in, ren_a, raddr_a, ren_b, raddr_b, clr,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b, busy, err
  );

  modport slave (
    input  wen, waddr, data_in, ren_a, raddr_a, ren_b, raddr_b, clr,
    output rdata_a, rvalid_a, rdata_b, rvalid_b, busy, err
  );
endinterface

// File: rtl/reg_mem_sweep.sv
// Init-sweep FSM: walks every entry after reset or clear, owns busy and the
// sweep write strobe/address.
module reg_mem_sweep
  import reg_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  output logic                 busy_o,
  output logic                 swe_o,
  output logic [ADDR_BITS-1:0] saddr_o
);
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(depth_of(ADDR_BITS) - 1);

  rm_state_t            state_q;
  logic [ADDR_BITS-1:0] cnt_q;
  logic                 busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          if (clr_i) begin
            cnt_q <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= READY;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ADDR_BITS'(1);
          end
        end
        READY: begin
          if (clr_i) begin
            state_q <= INIT;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= INIT;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // busy tracks INIT exactly, so it doubles as the sweep write strobe
  assign busy_o  = busy_q;
  assign swe_o   = busy_q;
  assign saddr_o = cnt_q;

endmodule

// File: rtl/reg_mem_dp.sv
// Register-file memory with one write port, two registered read ports and a
// self-initialising sweep; reads are write-first against the same-cycle write.
module reg_mem_dp
  import reg_mem_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 4,
  parameter int unsigned           ADDR_BITS  = 3,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic       clk,
  input  logic       rst,
  reg_mem_dp_if.slave bus
);
  localparam int unsigned DEPTH = depth_of(ADDR_BITS);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  busy, swe;
  logic [ADDR_BITS-1:0]  saddr;
  logic                  accept, err_d, err_q;
  logic                  mem_we;
  logic [ADDR_BITS-1:0]  mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  rvalid_a_d, rvalid_a_q, rvalid_b_d, rvalid_b_q;
  logic [DATA_WIDTH-1:0] rdata_a_d, rdata_a_q, rdata_b_d, rdata_b_q;

  reg_mem_sweep #(.ADDR_BITS(ADDR_BITS)) u_sweep (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (bus.clr),
    .busy_o (busy),
    .swe_o  (swe),
    .saddr_o(saddr)
  );

  always_comb begin
    // clr outranks any access in the same cycle
    accept     = ~busy & ~bus.clr;
    err_d      = (bus.wen | bus.ren_a | bus.ren_b) & ~accept;
    mem_we     = swe | (accept & bus.wen);
    mem_wa     = swe ? saddr : bus.waddr;
    mem_wd     = swe ? INIT_VAL : bus.data_in;
    rvalid_a_d = accept & bus.ren_a;
    rvalid_b_d = accept & bus.ren_b;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    if (rvalid_a_d)
      rdata_a_d = (bus.wen && bus.waddr == bus.raddr_a) ? bus.data_in : mem_q[bus.raddr_a];
    if (rvalid_b_d)
      rdata_b_d = (bus.wen && bus.waddr == bus.raddr_b) ? bus.data_in : mem_q[bus.raddr_b];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      err_q      <= err_d;
    end
  end

  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;
  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;
  assign bus.busy     = busy;
  assign bus.err      = err_q;

endmodule
